i2c_slave_regfile: RTL and testbench

Parametrised I2C slave in the board's system clock domain; next generation of the SCL-clocked single-byte 8-bit IO slave. Oversamples SCL/SDA on `clk`, answers a runtime 7-bit address taken from the switches, and exposes a bank of byte registers with an auto-incrementing pointer, readable and writable by the master. Sits between the SDA/SCL pins and the display/IO logic of the slave top; the top drives SDA as open-drain from `sda_oe`.

---
 rtl/i2c_slave_regfile_pkg.sv | 25 ++
 rtl/i2c_slave_regfile_line_sync.sv | 64 ++++++
 rtl/i2c_slave_regfile.sv | 218 +++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_regfile_pkg.sv
// Shared types and constants for the I2C register-file slave.
package i2c_slave_pkg;

  localparam int   BYTE_W = 8;
  localparam logic ACK    = 1'b0;
  localparam logic NACK   = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_IGNORE    = 4'd9
  } state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_slave_regfile_line_sync.sv
// i2c_line_sync: two-flop synchroniser plus registered level/rise/fall for one bus line.
// Define I2C_SLAVE_GLITCH_FILTER_EN to insert a 3-sample majority filter (+1 clk latency).
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic clean_s;
  logic lvl_r;
  logic rise_r;
  logic fall_r;

  // Synchroniser; idle bus level is high so reset to 1 to avoid a false edge
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= line_in;
      sync_r <= meta_r;
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] hist_r;

  // Two previous samples; a single-cycle pulse can never win the vote
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_r <= 2'b11;
    end else begin
      hist_r <= {hist_r[0], sync_r};
    end
  end

  assign clean_s = i2c_slave_pkg::maj3(sync_r, hist_r[0], hist_r[1]);
`else
  assign clean_s = sync_r;
`endif

  // Level and edge flags are registered together so they stay coherent
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_r  <= 1'b1;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      lvl_r  <= clean_s;
      rise_r <= clean_s & ~lvl_r;
      fall_r <= ~clean_s & lvl_r;
    end
  end

  assign level = lvl_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: clk-oversampled I2C slave with NUM_REGS byte registers and auto-increment pointer.
// Optional glitch filter on SCL/SDA enabled by defining I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_regfile
  import i2c_slave_pkg::*;
#(
  parameter  int NUM_REGS = 4,
  localparam int PTR_W    = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [6:0]                 slave_addr,
  input  logic                       scl_in,
  input  logic                       sda_in,
  output logic                       sda_oe,
  output logic [BYTE_W*NUM_REGS-1:0] regs_out,
  output logic                       wr_stb,
  output logic [PTR_W-1:0]           wr_idx,
  output logic                       busy
);

  logic scl_lvl_s, scl_rise_s, scl_fall_s;
  logic sda_lvl_s, sda_rise_s, sda_fall_s;
  logic start_s, stop_s;

  i2c_line_sync u_scl_sync (
    .clk     (clk),
    .rst     (rst),
    .line_in (scl_in),
    .level   (scl_lvl_s),
    .rise    (scl_rise_s),
    .fall    (scl_fall_s)
  );

  i2c_line_sync u_sda_sync (
    .clk     (clk),
    .rst     (rst),
    .line_in (sda_in),
    .level   (sda_lvl_s),
    .rise    (sda_rise_s),
    .fall    (sda_fall_s)
  );

  // An SDA edge coinciding with an SCL edge is treated as a data change
  assign start_s = sda_fall_s & scl_lvl_s & ~scl_rise_s & ~scl_fall_s;
  assign stop_s  = sda_rise_s & scl_lvl_s & ~scl_rise_s & ~scl_fall_s;

  state_e              state_r, state_s;
  logic [2:0]          cnt_r, cnt_s;
  logic [BYTE_W-1:0]   shift_r, shift_s;
  logic [BYTE_W-1:0]   tx_r, tx_s;
  logic [6:0]          addr_r, addr_s;
  logic [PTR_W-1:0]    ptr_r, ptr_s, ptr_inc_s;
  logic [BYTE_W-1:0]   regs_r [NUM_REGS];
  logic [BYTE_W-1:0]   regs_s [NUM_REGS];
  logic                sda_oe_r, sda_oe_s;
  logic                wr_stb_r, wr_stb_s;
  logic [PTR_W-1:0]    wr_idx_r, wr_idx_s;
  logic                busy_r, busy_s;
  logic [BYTE_W-1:0]   byte_s;

  assign ptr_inc_s = ptr_r + PTR_W'(1);
  assign byte_s    = {shift_r[6:0], sda_lvl_s};

  // Next-state and next-output logic; SCL edges take priority over START/STOP
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    shift_s  = shift_r;
    tx_s     = tx_r;
    addr_s   = addr_r;
    ptr_s    = ptr_r;
    regs_s   = regs_r;
    sda_oe_s = sda_oe_r;
    wr_stb_s = 1'b0;
    wr_idx_s = wr_idx_r;
    busy_s   = (state_r == ST_ADDR_ACK) ? 1'b1 : busy_r;

    if (scl_rise_s) begin
      case (state_r)
        ST_ADDR: begin
          shift_s = byte_s;
          cnt_s   = cnt_r + 3'd1;
          if (cnt_r == 3'd7) begin
            if ((byte_s[7:1] == addr_r) && (addr_r != 7'h00)) begin
              state_s = ST_ADDR_ACK;
            end else begin
              state_s = ST_IGNORE;
              busy_s  = 1'b0;
            end
          end else begin
            state_s = ST_ADDR;
          end
        end
        ST_ADDR_ACK: begin
          cnt_s = 3'd0;
          if (shift_r[0]) begin
            state_s = ST_RDATA;
            tx_s    = regs_r[ptr_r];
          end else begin
            state_s = ST_PTR;
          end
        end
        ST_PTR: begin
          shift_s = byte_s;
          cnt_s   = cnt_r + 3'd1;
          if (cnt_r == 3'd7) begin
            ptr_s   = byte_s[PTR_W-1:0];
            state_s = ST_PTR_ACK;
          end else begin
            state_s = ST_PTR;
          end
        end
        ST_WDATA: begin
          shift_s = byte_s;
          cnt_s   = cnt_r + 3'd1;
          if (cnt_r == 3'd7) begin
            regs_s[ptr_r] = byte_s;
            wr_stb_s      = 1'b1;
            wr_idx_s      = ptr_r;
            ptr_s         = ptr_inc_s;
            state_s       = ST_WDATA_ACK;
          end else begin
            state_s = ST_WDATA;
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          cnt_s   = 3'd0;
          state_s = ST_WDATA;
        end
        ST_RDATA: begin
          cnt_s = cnt_r + 3'd1;
          if (cnt_r == 3'd7) begin
            state_s = ST_RDATA_ACK;
          end else begin
            state_s = ST_RDATA;
          end
        end
        ST_RDATA_ACK: begin
          cnt_s = 3'd0;
          if (sda_lvl_s == ACK) begin
            ptr_s   = ptr_inc_s;
            tx_s    = regs_r[ptr_inc_s];
            state_s = ST_RDATA;
          end else begin
            state_s = ST_IGNORE;
          end
        end
        default: begin
          state_s = state_r;
        end
      endcase
    end else if (scl_fall_s) begin
      case (state_r)
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          sda_oe_s = 1'b1;
        end
        ST_RDATA: begin
          sda_oe_s = ~tx_r[7];
          tx_s     = {tx_r[6:0], 1'b0};
        end
        default: begin
          sda_oe_s = 1'b0;
        end
      endcase
    end else if (start_s) begin
      state_s  = ST_ADDR;
      cnt_s    = 3'd0;
      addr_s   = slave_addr;
      sda_oe_s = 1'b0;
    end else if (stop_s) begin
      state_s  = ST_IDLE;
      cnt_s    = 3'd0;
      sda_oe_s = 1'b0;
      busy_s   = 1'b0;
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 3'd0;
      shift_r  <= 8'h00;
      tx_r     <= 8'h00;
      addr_r   <= 7'h00;
      ptr_r    <= '0;
      regs_r   <= '{default: 8'h00};
      sda_oe_r <= 1'b0;
      wr_stb_r <= 1'b0;
      wr_idx_r <= '0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      shift_r  <= shift_s;
      tx_r     <= tx_s;
      addr_r   <= addr_s;
      ptr_r    <= ptr_s;
      regs_r   <= regs_s;
      sda_oe_r <= sda_oe_s;
      wr_stb_r <= wr_stb_s;
      wr_idx_r <= wr_idx_s;
      busy_r   <= busy_s;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
    assign regs_out[BYTE_W*k +: BYTE_W] = regs_r[k];
  end

  assign sda_oe = sda_oe_r;
  assign wr_stb = wr_stb_r;
  assign wr_idx = wr_idx_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Self-checking bench: bit-banged I2C master against a transaction-level register/pointer model.
module tb_i2c_slave_regfile;

  localparam int NUM_REGS = 4;
  localparam int PTR_W    = 2;
  localparam int Q        = 8;

  logic clk = 1'b0;
  logic rst;
  logic scl_m, sda_m;
  logic [6:0] slave_addr;
  logic sda_oe;
  logic [8*NUM_REGS-1:0] regs_out;
  logic wr_stb;
  logic [PTR_W-1:0] wr_idx;
  logic busy;
  logic sda_line;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regfile #(.NUM_REGS(NUM_REGS)) dut (
    .clk        (clk),
    .rst        (rst),
    .slave_addr (slave_addr),
    .scl_in     (scl_m),
    .sda_in     (sda_line),
    .sda_oe     (sda_oe),
    .regs_out   (regs_out),
    .wr_stb     (wr_stb),
    .wr_idx     (wr_idx),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] model_regs [NUM_REGS];
  int model_ptr;
  int stb_log[$];
  int oe_cnt = 0;

  always @(negedge clk) begin
    if (wr_stb) stb_log.push_back(int'(wr_idx));
    if (sda_oe) oe_cnt = oe_cnt + 1;
  end

  function automatic logic [8*NUM_REGS-1:0] model_flat();
    logic [8*NUM_REGS-1:0] f;
    for (int k = 0; k < NUM_REGS; k++) f[8*k +: 8] = model_regs[k];
    return f;
  endfunction

  function automatic bit addr_match(input logic [6:0] a);
    return (a == slave_addr) && (a != 7'h00);
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q); sda_m = 1'b0;
    wait_clk(Q); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(Q); sda_m = 1'b0;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q);
  endtask

  task automatic bus_bit(input logic b, input bit glitch, output logic r);
    wait_clk(Q); sda_m = b;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(2);
    if (glitch) begin
      sda_m = ~b; wait_clk(1); sda_m = b;
    end else begin
      wait_clk(1);
    end
    wait_clk(3); r = sda_line;
    wait_clk(2); scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_pos, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], (i == glitch_pos), r);
    bus_bit(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, 1'b0, r);
      d[i] = r;
    end
    bus_bit(mack, 1'b0, r);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] p, input logic [31:0] data, input int n);
    logic ack;
    bit m;
    int start_idx, oe_before;
    int exp_idx[$];
    m = addr_match(a);
    start_idx = stb_log.size();
    oe_before = oe_cnt;
    bus_start();
    write_byte({a, 1'b0}, -1, ack);
    checks++;
    if (ack !== (m ? 1'b0 : 1'b1)) begin errors++; $display("FAIL addr_ack a=%h: got %b expected %b", a, ack, !m); end
    if (m) begin
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_ack: got %b expected 1", busy); end
    end
    write_byte(p, -1, ack);
    checks++;
    if (ack !== (m ? 1'b0 : 1'b1)) begin errors++; $display("FAIL ptr_ack: got %b expected %b", ack, !m); end
    if (m) model_ptr = int'(p) % NUM_REGS;
    for (int i = 0; i < n; i++) begin
      write_byte(data[31-8*i -: 8], -1, ack);
      checks++;
      if (ack !== (m ? 1'b0 : 1'b1)) begin errors++; $display("FAIL data_ack byte %0d: got %b expected %b", i, ack, !m); end
      if (m) begin
        model_regs[model_ptr] = data[31-8*i -: 8];
        exp_idx.push_back(model_ptr);
        model_ptr = (model_ptr + 1) % NUM_REGS;
      end
    end
    bus_stop();
    checks++;
    if (stb_log.size() - start_idx != exp_idx.size()) begin
      errors++; $display("FAIL wr_stb_count: got %0d expected %0d", stb_log.size() - start_idx, exp_idx.size());
    end else begin
      for (int i = 0; i < exp_idx.size(); i++) begin
        checks++;
        if (stb_log[start_idx+i] != exp_idx[i]) begin
          errors++; $display("FAIL wr_idx %0d: got %0d expected %0d", i, stb_log[start_idx+i], exp_idx[i]);
        end
      end
    end
    checks++;
    if (regs_out !== model_flat()) begin errors++; $display("FAIL regs_after_write: got %h expected %h", regs_out, model_flat()); end
    if (!m) begin
      checks++;
      if (oe_cnt != oe_before) begin errors++; $display("FAIL sda_oe_silent: got %0d drive cycles expected 0", oe_cnt - oe_before); end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_stop: got %b expected 0", busy); end
  endtask

  task automatic do_read(input logic [6:0] a, input int n, input bit set_ptr, input logic [7:0] p);
    logic ack;
    logic [7:0] d, exp;
    bit m;
    m = addr_match(a);
    if (set_ptr) begin
      bus_start();
      write_byte({a, 1'b0}, -1, ack);
      write_byte(p, -1, ack);
      if (m) model_ptr = int'(p) % NUM_REGS;
    end
    bus_start();
    write_byte({a, 1'b1}, -1, ack);
    checks++;
    if (ack !== (m ? 1'b0 : 1'b1)) begin errors++; $display("FAIL rd_addr_ack: got %b expected %b", ack, !m); end
    for (int i = 0; i < n; i++) begin
      read_byte((i < n-1) ? 1'b0 : 1'b1, d);
      exp = m ? model_regs[model_ptr] : 8'hFF;
      checks++;
      if (d !== exp) begin errors++; $display("FAIL read_data byte %0d: got %h expected %h", i, d, exp); end
      if (m && (i < n-1)) model_ptr = (model_ptr + 1) % NUM_REGS;
    end
    wait_clk(6);
    checks++;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL sda_released_after_nack: got %b expected 0", sda_oe); end
    bus_stop();
  endtask

  task automatic test_reset();
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; slave_addr = 7'h27;
    wait_clk(5);
    checks += 5;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_sda_oe: got %b expected 0", sda_oe); end
    if (regs_out !== '0) begin errors++; $display("FAIL rst_regs: got %h expected 0", regs_out); end
    if (wr_stb !== 1'b0) begin errors++; $display("FAIL rst_wr_stb: got %b expected 0", wr_stb); end
    if (wr_idx !== '0) begin errors++; $display("FAIL rst_wr_idx: got %h expected 0", wr_idx); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    rst = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) model_regs[k] = 8'h00;
    model_ptr = 0;
    wait_clk(Q);
  endtask

  task automatic test_write_basic();
    slave_addr = 7'h27;
    do_write(7'h27, 8'h01, 32'hA53C_0000, 2);
  endtask

  task automatic test_nomatch();
    slave_addr = 7'h27;
    do_write(7'h28, 8'h00, 32'hDEAD_0000, 2);
    slave_addr = 7'h00;
    do_write(7'h00, 8'h00, 32'h5500_0000, 1);
    slave_addr = 7'h27;
  endtask

  task automatic test_wrap();
    do_write(7'h27, 8'h03, 32'h1122_0000, 2);
  endtask

  task automatic test_read();
    do_read(7'h27, 2, 1'b1, 8'h02);
    do_read(7'h27, 3, 1'b0, 8'h00);
  endtask

  task automatic test_stop_mid();
    logic ack, r;
    int start_idx;
    start_idx = stb_log.size();
    bus_start();
    write_byte({7'h27, 1'b0}, -1, ack);
    write_byte(8'h01, -1, ack);
    model_ptr = 1;
    for (int i = 0; i < 4; i++) bus_bit(1'b1, 1'b0, r);
    wait_clk(Q); sda_m = 1'b0;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(2);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_before_stop_detect: got %b expected 1", busy); end
    wait_clk(4);
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_mid_stop: got %b expected 0", busy); end
    if (stb_log.size() != start_idx) begin errors++; $display("FAIL mid_stop_no_write: got %0d strobes expected 0", stb_log.size() - start_idx); end
    if (regs_out !== model_flat()) begin errors++; $display("FAIL mid_stop_regs: got %h expected %h", regs_out, model_flat()); end
    wait_clk(Q);
    // Pointer 1 must still be in effect after the aborted byte
    do_read(7'h27, 1, 1'b0, 8'h00);
  endtask

  task automatic test_rst_mid_read();
    logic r;
    logic [7:0] ab;
    ab = {7'h27, 1'b1};
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(ab[i], 1'b0, r);
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(3);
    checks++;
    if (sda_oe !== 1'b1) begin errors++; $display("FAIL ack_driven_before_rst: got %b expected 1", sda_oe); end
    rst = 1'b1;
    wait_clk(1);
    checks += 3;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_sda_oe: got %b expected 0", sda_oe); end
    if (regs_out !== '0) begin errors++; $display("FAIL rst_mid_regs: got %h expected 0", regs_out); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    rst = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) model_regs[k] = 8'h00;
    model_ptr = 0;
    wait_clk(Q); scl_m = 1'b0;
    bus_stop();
  endtask

  task automatic test_glitch();
    logic ack;
    int start_idx;
    start_idx = stb_log.size();
    bus_start();
    write_byte({7'h27, 1'b0}, -1, ack);
    write_byte(8'h00, -1, ack);
    model_ptr = 0;
    write_byte(8'h5C, 1, ack);
    bus_stop();
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    model_regs[0] = 8'h5C;
    model_ptr = 1;
`endif
    checks += 2;
    if (stb_log.size() - start_idx != ((model_ptr == 1) ? 1 : 0)) begin
      errors++; $display("FAIL glitch_strobes: got %0d expected %0d", stb_log.size() - start_idx, model_ptr);
    end
    if (regs_out !== model_flat()) begin errors++; $display("FAIL glitch_regs: got %h expected %h", regs_out, model_flat()); end
    do_read(7'h27, 1, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    logic [6:0] a;
    for (int it = 0; it < 10; it++) begin
      slave_addr = 7'($urandom_range(1, 127));
      a = ($urandom_range(0, 3) == 0) ? (slave_addr ^ 7'($urandom_range(1, 127))) : slave_addr;
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, 8'($urandom), 32'($urandom), $urandom_range(1, 4));
      end else begin
        do_read(a, $urandom_range(1, 3), ($urandom_range(0, 1) == 1), 8'($urandom));
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_nomatch();
    test_wrap();
    test_read();
    test_stop_mid();
    test_rst_mid_read();
    slave_addr = 7'h27;
    do_write(7'h27, 8'h00, 32'h1234_5678, 4);
    test_glitch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
